// File: rtl/mul32_pkg.sv
// Shared types and constants for the 32x32 sequential multiplier.
// Holds the FSM state enum and iteration sizing.
package mul32_pkg;

  localparam int WIDTH      = 32;
  localparam int ITERATIONS = 32;
  localparam int CNT_W      = 5;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/mul32_seq_adder32.sv
// 32-bit ripple-carry adder used by the shift-add step.
// Carry-out is the true bit-32 carry of a + b + cin.
module adder32
  import mul32_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  logic [WIDTH:0] carry;

  // Bit-serial ripple of the carry chain.
  always_comb begin
    carry    = '0;
    sum_o    = '0;
    carry[0] = cin_i;
    for (int i = 0; i < WIDTH; i++) begin
      sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1] = (a_i[i] & b_i[i])
                 | (carry[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry[WIDTH];
  end

endmodule

// File: rtl/mul32_seq.sv
// Sequential 32x32 unsigned shift-add multiplier.
// One add/shift per cycle, fixed 32-cycle latency.
module mul32_seq
  import mul32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] product
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      mcand_q, mcand_d;
  // {high, low}; the add carry lands in bit 63
  // after the shift, so it is never stored above.
  logic [63:0]      acc_q, acc_d;

  logic [31:0]      add_sum;
  logic             add_cout;
  logic [31:0]      hi_sel;
  logic             c_sel;

  adder32 u_add (
    .a_i    (acc_q[63:32]),
    .b_i    (mcand_q),
    .cin_i  (1'b0),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // Select add or pass-through for the high half.
  always_comb begin
    c_sel  = 1'b0;
    hi_sel = acc_q[63:32];
    if (acc_q[0]) begin
      c_sel  = add_cout;
      hi_sel = add_sum;
    end
  end

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mcand_d = a;
          acc_d   = {32'd0, b};
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = {c_sel, hi_sel, acc_q[31:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
    end
  end

  assign product = acc_q;

endmodule

// File: tb/tb_mul32_seq.sv
// Directed scoreboard bench for mul32_seq.
// Expected products are queued on accept, popped on out_valid.
module tb_mul32_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;

  int checks   = 0;
  int failures = 0;

  logic [63:0] sb[$];

  mul32_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Drive an operand pair and accept it on the next edge.
  task automatic start(input logic [31:0] ta,
                       input logic [31:0] tb);
    logic [63:0] e;
    a        = ta;
    b        = tb;
    in_valid = 1'b1;
    check("ready_before_accept", 64'(in_ready), 64'd1);
    @(posedge clk);
    e = {32'd0, ta} * {32'd0, tb};
    sb.push_back(e);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for the result, check latency, product, hold and release.
  task automatic finish(input string tag,
                        input int    lat_done,
                        input int    hold);
    int          n;
    logic [63:0] e;
    logic [63:0] held;
    n = lat_done;
    while (!out_valid && n < 45) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd32);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_product"}, product, e);
    end
    held = product;
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_prod"}, product, held);
      check({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
      check({tag, "_hold_vld"}, 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_rdy_after"}, 64'(in_ready), 64'd1);
    check({tag, "_vld_after"}, 64'(out_valid), 64'd0);
    check({tag, "_prod_kept"}, product, held);
  endtask

  int seen;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_product", product, 64'd0);
    rst = 1'b0;

    start(32'h0000_0069, 32'h0000_1000);
    check("run_in_ready", 64'(in_ready), 64'd0);
    finish("basic", 0, 0);

    start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish("allones", 0, 0);

    start(32'h1234_5678, 32'h0000_0000);
    finish("zero_b", 0, 0);

    start(32'h0000_0000, 32'hDEAD_BEEF);
    finish("zero_a", 0, 10);

    start(32'h8000_0001, 32'h8000_0003);
    finish("msb", 0, 2);

    for (int k = 0; k < 3; k++) begin
      start($urandom, $urandom);
      finish("rand", 0, k);
    end

    // Abort mid-run: no result may follow.
    a        = 32'd7;
    b        = 32'd9;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_product", product, 64'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("abort_no_result", 64'(seen), 64'd0);

    start(32'd3, 32'd5);
    finish("after_abort", 0, 0);

    // Extra requests during RUN must be ignored.
    start(32'd2, 32'd3);
    a = 32'd1;
    b = 32'd1;
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("ignore_in_ready", 64'(in_ready), 64'd0);
    finish("ignore", 20, 0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("ignore_single", 64'(seen), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
